// File: rtl/data_memory_responder.sv
// data_memory_responder: load/store responder owning a word-addressed data RAM.
// Optional wait states hold stall_o until the latched access completes.
module data_memory_responder #(
  parameter int ADDR       = 16,
  parameter int W_OPR      = 32,
  parameter int DEPTH_LOG2 = 10,
  parameter int WAIT       = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rd_i,
  input  logic             wr_i,
  input  logic [ADDR-1:0]  addr_i,
  input  logic [W_OPR-1:0] wdata_i,
  output logic [W_OPR-1:0] rdata_o,
  output logic             stall_o
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  localparam bit ZW = WAIT == 0;
  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [DEPTH_LOG2-1:0] idx_q, idx_d, acc_idx;
  logic [W_OPR-1:0]      wdata_q, wdata_d, acc_wdata, rdata_q, rdata_d;
  logic                  wr_q, wr_d, acc_wr, acc_en, stall, req;
  logic [W_OPR-1:0]      mem [0:(1<<DEPTH_LOG2)-1];
  logic                  unused_hi;
  assign req       = rd_i | wr_i;
  assign unused_hi = ^addr_i[ADDR-1:DEPTH_LOG2];
  // Zero-wait mode services the live request; otherwise the latched copy.
  assign acc_wr    = ZW ? wr_i : wr_q;
  assign acc_idx   = ZW ? addr_i[DEPTH_LOG2-1:0] : idx_q;
  assign acc_wdata = ZW ? wdata_i : wdata_q;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;
    acc_en  = 1'b0;
    stall   = 1'b0;
    if (ZW) begin
      acc_en = req;
    end else begin
      case (state_q)
        IDLE: begin
          stall = req;
          if (req) begin
            idx_d   = addr_i[DEPTH_LOG2-1:0];
            wdata_d = wdata_i;
            wr_d    = wr_i;
            cnt_d   = 4'(WAIT - 1);
            state_d = BUSY;
          end
        end
        BUSY: begin
          stall = 1'b1;
          if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
          else begin
            acc_en  = 1'b1;
            state_d = DONE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end
  // Reset gating keeps a held request from writing or stalling while in reset.
  assign stall_o = reset & stall;
  assign rdata_d = (reset & acc_en & ~acc_wr) ? mem[acc_idx] : rdata_q;
  assign rdata_o = rdata_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      rdata_q <= rdata_d;
    end
  end
  always_ff @(posedge clk) begin
    if (reset && acc_en && acc_wr) mem[acc_idx] <= acc_wdata;
  end
endmodule

// File: tb/tb_data_memory_responder.sv
// tb_data_memory_responder: three responders (WAIT 0, 2, 3) checked every cycle
// against a request-age model, plus hand-computed literal expectations.
module tb_data_memory_responder;
  localparam int WT[3] = '{0, 2, 3};
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        rd[3], wr[3], stall[3];
  logic [15:0] addr[3];
  logic [31:0] wdata[3], rdata[3];
  int          n_tests = 0, n_fail = 0;
  int          st;
  logic [31:0] dr;
  logic [31:0] m_mem[3][1024];
  logic [31:0] m_rdata[3] = '{0, 0, 0};
  int          m_age[3] = '{-1, -1, -1};
  logic        m_wr[3];
  logic [9:0]  m_idx[3];
  logic [31:0] m_wd[3];

  always #5 clk = ~clk;

  data_memory_responder #(.WAIT(0)) u_w0 (.clk(clk), .reset(rst_n), .rd_i(rd[0]), .wr_i(wr[0]),
    .addr_i(addr[0]), .wdata_i(wdata[0]), .rdata_o(rdata[0]), .stall_o(stall[0]));
  data_memory_responder #(.WAIT(2)) u_w2 (.clk(clk), .reset(rst_n), .rd_i(rd[1]), .wr_i(wr[1]),
    .addr_i(addr[1]), .wdata_i(wdata[1]), .rdata_o(rdata[1]), .stall_o(stall[1]));
  data_memory_responder #(.WAIT(3)) u_w3 (.clk(clk), .reset(rst_n), .rd_i(rd[2]), .wr_i(wr[2]),
    .addr_i(addr[2]), .wdata_i(wdata[2]), .rdata_o(rdata[2]), .stall_o(stall[2]));

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Age counts cycles since a request was accepted: the request cycle is age 0,
  // the access lands at the end of age WAIT, and age WAIT+1 is the free cycle.
  function automatic logic exp_stall(int k);
    return rst_n && WT[k] > 0 &&
           ((m_age[k] < 0 && (rd[k] || wr[k])) || (m_age[k] >= 1 && m_age[k] <= WT[k]));
  endfunction

  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 3; k++) begin
      if (!rst_n) begin
        m_age[k]   <= -1;
        m_rdata[k] <= '0;
      end else if (WT[k] == 0) begin
        if (wr[k]) m_mem[k][addr[k][9:0]] <= wdata[k];
        else if (rd[k]) m_rdata[k] <= m_mem[k][addr[k][9:0]];
      end else if (m_age[k] < 0) begin
        if (rd[k] || wr[k]) begin
          m_wr[k]  <= wr[k];
          m_idx[k] <= addr[k][9:0];
          m_wd[k]  <= wdata[k];
          m_age[k] <= 1;
        end
      end else begin
        if (m_age[k] == WT[k]) begin
          if (m_wr[k]) m_mem[k][m_idx[k]] <= m_wd[k];
          else m_rdata[k] <= m_mem[k][m_idx[k]];
        end
        m_age[k] <= (m_age[k] == WT[k] + 1) ? -1 : m_age[k] + 1;
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("stall_w%0d", WT[k]), 32'(stall[k]), 32'(exp_stall(k)));
      chk($sformatf("rdata_w%0d", WT[k]), rdata[k], m_rdata[k]);
    end
  end

  // Called just after a rising edge; holds the request for the whole access.
  task automatic acc(int k, logic r, logic w, logic [15:0] a, logic [31:0] d,
                     output int s, output logic [31:0] done_rd);
    rd[k] = r; wr[k] = w; addr[k] = a; wdata[k] = d;
    s = 0;
    done_rd = '0;
    repeat (WT[k] == 0 ? 1 : WT[k] + 2) begin
      @(negedge clk);
      s += int'(stall[k]);
      done_rd = rdata[k];
      @(posedge clk);
      #1;
    end
    rd[k] = 1'b0; wr[k] = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      rd[k] = 1'b0; wr[k] = 1'b0; addr[k] = '0; wdata[k] = '0;
    end
    #1 rst_n = 1'b0;
    #1;
    chk("reset_rdata", rdata[2], 32'h0);
    chk("reset_stall", 32'(stall[2]), 32'h0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    acc(0, 1'b0, 1'b1, 16'h0010, 32'hDEADBEEF, st, dr);
    chk("w0_store_stall", st, 0);
    acc(0, 1'b1, 1'b0, 16'h0010, 32'h0, st, dr);
    chk("w0_load_stall", st, 0);
    chk("w0_load_data", rdata[0], 32'hDEADBEEF);
    acc(0, 1'b0, 1'b1, 16'h0030, 32'hA5A5A5A5, st, dr);
    acc(0, 1'b1, 1'b0, 16'h0030, 32'h0, st, dr);
    acc(0, 1'b1, 1'b1, 16'h0020, 32'h12345678, st, dr);
    chk("w0_both_keeps_rdata", rdata[0], 32'hA5A5A5A5);
    acc(0, 1'b1, 1'b0, 16'h0020, 32'h0, st, dr);
    chk("w0_both_stored", rdata[0], 32'h12345678);
    acc(0, 1'b0, 1'b1, 16'h0401, 32'h00000011, st, dr);
    acc(0, 1'b1, 1'b0, 16'h0001, 32'h0, st, dr);
    chk("w0_alias", rdata[0], 32'h00000011);
    acc(2, 1'b0, 1'b1, 16'h0005, 32'h00000077, st, dr);
    chk("w3_store_stall", st, 4);
    acc(2, 1'b1, 1'b0, 16'h0005, 32'h0, st, dr);
    chk("w3_load_stall", st, 4);
    chk("w3_done_data", dr, 32'h00000077);
    repeat (3) begin @(posedge clk); #1; end
    chk("w3_hold_data", rdata[2], 32'h00000077);
    acc(1, 1'b0, 1'b1, 16'h0003, 32'hCAFEF00D, st, dr);
    chk("w2_store_stall", st, 3);
    acc(1, 1'b1, 1'b0, 16'h0003, 32'h0, st, dr);
    chk("w2_load_stall", st, 3);
    chk("w2_load_data", dr, 32'hCAFEF00D);
    acc(2, 1'b0, 1'b1, 16'h0008, 32'h00000099, st, dr);
    wr[2] = 1'b1; addr[2] = 16'h0008; wdata[2] = 32'h00000055;
    @(posedge clk); #1;
    @(posedge clk); #1;
    #2 rst_n = 1'b0;
    wr[2] = 1'b0;
    #1;
    chk("abort_stall", 32'(stall[2]), 32'h0);
    chk("abort_rdata", rdata[2], 32'h0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    acc(2, 1'b1, 1'b0, 16'h0008, 32'h0, st, dr);
    chk("abort_no_write", dr, 32'h00000099);
    chk("abort_load_stall", st, 4);
    repeat (2) begin @(posedge clk); #1; end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/data_memory_responder.md
Name: data_memory_responder

Overview:
- Responder end of the execute stage's load/store interface.
- Accepts one word-wide load or store request per cycle and owns a synchronous word-addressed data RAM.
- Returns load data in the cycle after the request completes.
- Parameter-programmable wait states; during them it asserts stall to freeze the pipeline until the access completes.

Parameters:
ADDR, 16, width of the load/store address bus (word address)
W_OPR, 32, data word width
DEPTH_LOG2, 10, log2 of RAM depth in words; index = addr_i[DEPTH_LOG2-1:0]
WAIT, 0, wait states per access (0..15); 0 gives single-cycle, stall-free operation

Ports:
clk  input  1  clock; all state changes on rising edge
reset  input  1  asynchronous, active-low reset
rd_i  input  1  load request, already qualified with instruction valid
wr_i  input  1  store request, already qualified with instruction valid
addr_i  input  ADDR  word address, combinational from execute stage
wdata_i  input  W_OPR  store data
rdata_o  output  W_OPR  load data register, consumed by execute stage in the cycle after completion
stall_o  output  1  pipeline hold request, combinational

Behaviour:
- Reset (async, reset low):
  - state <= IDLE, cnt <= 0, rdata_o <= 0, stall_o = 0, latched request cleared.
  - RAM contents are not reset.
  - A reset asserted mid-access aborts the access; a pending store is not written.
- Request = rd_i | wr_i. If both are high, the store wins and the load is ignored; rdata_o keeps its value.
- Addresses alias: bits above DEPTH_LOG2 are ignored.
- WAIT == 0:
  - State stays IDLE and stall_o is constant 0.
  - Store: RAM[idx] <= wdata_i at the edge ending the request cycle.
  - Load: rdata_o <= RAM[idx] at that same edge, so data is valid the following cycle.
  - A load in the cycle right after a store to the same address returns the new data.
- WAIT > 0, FSM IDLE -> BUSY -> DONE -> IDLE:
  - IDLE:
    - stall_o = request.
    - On request, latch addr, wdata and op; cnt <= WAIT-1; go BUSY.
  - BUSY:
    - stall_o = 1.
    - If cnt != 0: cnt <= cnt-1.
    - If cnt == 0: perform the latched access (store writes RAM; load updates rdata_o) and go DONE.
    - Inputs are ignored in this state; the latched copy is used.
  - DONE:
    - stall_o = 0, so the pipeline advances past the serviced instruction.
    - The inputs still present the same request; it is ignored.
    - Go IDLE unconditionally.
- Stall behaviour with WAIT > 0:
  - Total stall per access = WAIT+1 cycles (request cycle plus WAIT BUSY cycles).
  - Data is visible on rdata_o from the DONE cycle onward.
- rdata_o holds its value until the next completed load. Stores never change it.
- No request in IDLE: no state change; rdata_o and RAM are unchanged.
- Back-to-back requests are legal. A new request may appear in the cycle after DONE.

Test Plan:
- WAIT=0: store 0xDEADBEEF @0x0010, next cycle load @0x0010 -> rdata_o = 0xDEADBEEF one cycle after the load cycle; stall_o never high.
- WAIT=0: rd_i=wr_i=1 @0x0020 with wdata 0x12345678 and previous rdata_o 0xA5A5A5A5 -> RAM[0x20] = 0x12345678, rdata_o stays 0xA5A5A5A5.
- WAIT=3: load @0x0005 holding 0x00000077 -> stall_o high for exactly 4 cycles, stall_o low in DONE with rdata_o = 0x77, no second access issued.
- WAIT=2: store 0xCAFEF00D @0x0003 then immediate load @0x0003 -> two separate 3-cycle stall windows; load returns 0xCAFEF00D.
- DEPTH_LOG2=10: store 0x11 @0x0401, load @0x0001 -> 0x00000011 (aliasing).
- WAIT=3: assert reset in the second BUSY cycle of a store of 0x55 @0x0008 whose prior content is 0x99 -> stall_o and rdata_o go 0 immediately; state IDLE; a subsequent load @0x0008 returns 0x99.
